// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode; flush wins over push/pop,
// and the head output holds its last shown value while empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_hold;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_count   = r_count;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = o_empty ? r_hold : r_mem[r_rd];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_hold  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (!o_empty) r_hold <= r_mem[r_rd];
            if (i_flush) begin
                r_wr    <= '0;
                r_rd    <= '0;
                r_count <= '0;
            end else begin
                if (w_do_push) begin
                    r_mem[r_wr] <= i_wdata;
                    r_wr        <= r_wr + AW'(1);
                end
                if (w_do_pop) r_rd <= r_rd + AW'(1);
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps one memory request in flight and
// buffers returned words for decode. Redirects drop any in-flight response.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] PC_STEP    = DEFAULT_PC_STEP,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_target,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] w_req_pc_nxt;
    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wentry;

    assign w_wentry      = '{instr: i_imem_rdata, pc: r_req_pc};
    assign o_instr_valid = ~w_empty;
    assign w_pop         = o_instr_valid & i_instr_ready;
    assign o_instr       = w_head.instr;
    assign o_instr_pc    = w_head.pc;
    assign o_imem_addr   = r_pc;
    // State resets to FETCH asynchronously; keep the request low while held in reset.
    assign o_imem_req    = w_req & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_req_pc <= w_req_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_req_pc_nxt = r_req_pc;
        w_req        = 1'b0;
        w_push       = 1'b0;
        if (i_br_taken) begin
            w_pc_nxt = align_pc(i_br_target);
            case (r_state)
                ST_WAIT, ST_DISCARD: w_state_nxt = i_imem_rvalid ? ST_FETCH : ST_DISCARD;
                default:             w_state_nxt = ST_FETCH;
            endcase
        end else begin
            case (r_state)
                ST_FETCH: begin
                    w_req = (w_count < CW'(FIFO_DEPTH));
                    if (w_req && i_imem_gnt) begin
                        w_req_pc_nxt = r_pc;
                        w_pc_nxt     = r_pc + PC_STEP;
                        w_state_nxt  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_imem_rvalid) begin
                        w_push      = ~w_full;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (i_imem_rvalid) w_state_nxt = ST_FETCH;
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_br_taken),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural queue model checked every cycle, a
// directed vector table, multi-cycle corner sequences and a wrap instance.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] MASK  = 32'hA5A5_A5A5;
    localparam int          DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        br_taken, ready, gnt, rvalid;
    logic [31:0] br_target, rdata;
    logic        req, valid;
    logic [31:0] addr, instr, ipc;

    logic        w_gnt, w_rvalid, w_req, w_valid;
    logic [31:0] w_rdata, w_addr, w_instr, w_ipc;

    fetch_unit #(.RESET_PC(32'h0), .PC_STEP(32'd4), .FIFO_DEPTH(DEPTH)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_br_taken(br_taken), .i_br_target(br_target),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt), .i_imem_rvalid(rvalid),
        .i_imem_rdata(rdata), .o_instr_valid(valid), .i_instr_ready(ready),
        .o_instr(instr), .o_instr_pc(ipc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4), .FIFO_DEPTH(DEPTH)) u_dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_br_taken(1'b0), .i_br_target(32'h0),
        .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_gnt(w_gnt), .i_imem_rvalid(w_rvalid),
        .i_imem_rdata(w_rdata), .o_instr_valid(w_valid), .i_instr_ready(1'b1),
        .o_instr(w_instr), .o_instr_pc(w_ipc)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // reference model: buffered instructions, next PC, in-flight/stale flags
    ent_t        q[$];
    logic [31:0] m_pc, m_req_pc;
    bit          m_pend, m_stale;

    // memory models
    int          mem_cnt, lat_min, lat_max, gnt_pct, grants;
    logic [31:0] mem_addr;
    bit          w_pend;
    logic [31:0] w_maddr;
    ent_t        wq[$];

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_ipc, s_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit br, input logic [31:0] tgt, input bit rdy);
        bit e_req;
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = '0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rvalid = 1'b1;
                rdata  = mem_addr ^ MASK;
            end
        end
        gnt       = ($urandom_range(0, 99) < gnt_pct);
        br_taken  = br;
        br_target = tgt;
        ready     = rdy;
        w_rvalid  = w_pend;
        w_rdata   = w_maddr ^ MASK;
        w_pend    = 1'b0;
        w_gnt     = 1'b1;
        #1;
        s_req = req; s_addr = addr; s_valid = valid; s_ipc = ipc; s_instr = instr;
        e_req = !m_pend && (q.size() < DEPTH) && !br;
        chk("req", 32'(req), 32'(e_req));
        chk("addr", addr, m_pc);
        chk("valid", 32'(valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("instr", instr, q[0].instr);
            chk("instr_pc", ipc, q[0].pc);
        end
        if (req && gnt) begin
            mem_cnt  = $urandom_range(lat_min, lat_max);
            mem_addr = addr;
            grants++;
        end
        if (w_req && w_gnt) begin
            w_pend  = 1'b1;
            w_maddr = w_addr;
        end
        if (w_valid) wq.push_back({w_instr, w_ipc});
        if (br) begin
            q.delete();
            m_pc = tgt & ~32'h3;
            if (m_pend) begin
                if (rvalid) begin
                    m_pend  = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (m_pend && rvalid) begin
                if (!m_stale) q.push_back({rdata, m_req_pc});
                m_pend  = 1'b0;
                m_stale = 1'b0;
            end else if (e_req && gnt) begin
                m_pend   = 1'b1;
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        br_taken = 1'b0; br_target = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
        w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0; w_pend = 1'b0;
        mem_cnt = 0;
        q.delete();
        m_pc = 32'h0; m_pend = 1'b0; m_stale = 1'b0;
        #1;
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", ipc, 32'h0);
        chk("rst_addr", addr, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[9];

    initial begin
        int k;
        vt[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b0, 32'h04, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h0};
        vt[3] = '{1'b1, 1'b0, 32'h08, 1'b0, 32'h0};
        vt[4] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        vt[5] = '{1'b1, 1'b0, 32'h0C, 1'b0, 32'h0};
        vt[6] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h8};
        vt[7] = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h0};
        vt[8] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

        lat_min = 1; lat_max = 1; gnt_pct = 100; grants = 0;
        mem_addr = '0; w_maddr = '0; m_req_pc = '0;

        // streaming with single-cycle memory
        do_reset();
        foreach (vt[i]) begin
            cyc(1'b0, 32'h0, vt[i].rdy);
            chk("t1_req", 32'(s_req), 32'(vt[i].e_req));
            chk("t1_addr", s_addr, vt[i].e_addr);
            chk("t1_valid", 32'(s_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk("t1_pc", s_ipc, vt[i].e_pc);
                chk("t1_instr", s_instr, vt[i].e_pc ^ MASK);
            end
        end

        // decode stalled: buffer fills to depth, then drains in order
        do_reset();
        grants = 0;
        repeat (20) cyc(1'b0, 32'h0, 1'b0);
        chk("t2_grants", 32'(grants), 32'd2);
        chk("t2_req_full", 32'(s_req), 32'h0);
        chk("t2_head", s_ipc, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("t2_pop0", s_ipc, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("t2_pop4", s_ipc, 32'h4);
        chk("t2_resume_req", 32'(s_req), 32'h1);
        chk("t2_resume_addr", s_addr, 32'h8);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("t2_pop8_valid", 32'(s_valid), 32'h1);
        chk("t2_pop8", s_ipc, 32'h8);

        // redirect while waiting on a 3-cycle memory
        do_reset();
        lat_min = 3; lat_max = 3;
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'h0000_1003, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("t3_req_discard", 32'(s_req), 32'h0);
        chk("t3_pc_target", s_addr, 32'h1000);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("t3_req", 32'(s_req), 32'h1);
        chk("t3_addr", s_addr, 32'h1000);
        k = 0;
        do begin
            cyc(1'b0, 32'h0, 1'b1);
            k++;
        end while (!s_valid && k < 20);
        chk("t3_valid_seen", 32'(s_valid), 32'h1);
        chk("t3_first_pc", s_ipc, 32'h1000);

        // redirect coinciding with the response, one entry buffered
        do_reset();
        lat_min = 1; lat_max = 1;
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t4_one_buffered", 32'(s_valid), 32'h1);
        cyc(1'b1, 32'h0000_2000, 1'b0);
        chk("t4_req_br", 32'(s_req), 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("t4_flushed", 32'(s_valid), 32'h0);
        chk("t4_req", 32'(s_req), 32'h1);
        chk("t4_addr", s_addr, 32'h2000);

        // asynchronous reset while a request is in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        repeat (5) cyc(1'b0, 32'h0, 1'b0);
        chk("t6_pre_valid", 32'(s_valid), 32'h1);
        #2;
        do_reset();
        cyc(1'b0, 32'h0, 1'b1);
        chk("t6_restart_req", 32'(s_req), 32'h1);
        chk("t6_restart_addr", s_addr, 32'h0);

        // randomized traffic
        do_reset();
        lat_min = 1; lat_max = 3; gnt_pct = 70;
        repeat (800)
            cyc($urandom_range(0, 99) < 4, $urandom, 1'($urandom_range(0, 1)));
        #2;
        do_reset();
        repeat (300)
            cyc($urandom_range(0, 99) < 6, $urandom, 1'($urandom_range(0, 1)));

        // wrap instance: first three instructions after the initial reset
        chk("t5_count", 32'(wq.size() >= 3), 32'h1);
        if (wq.size() >= 3) begin
            chk("t5_pc0", wq[0].pc, 32'hFFFF_FFF8);
            chk("t5_pc1", wq[1].pc, 32'hFFFF_FFFC);
            chk("t5_pc2", wq[2].pc, 32'h0000_0000);
            chk("t5_instr2", wq[2].instr, MASK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
